// File: rtl/region_capture.sv
// Region RAM writer: converts a fixed window of the incoming RGB stream to 8-bit
// gray and writes it in raster order, one frame per capture request.
module region_capture #(
    parameter logic [11:0] WIN_X  = 12'd10,
    parameter logic [11:0] WIN_Y  = 12'd318,
    parameter logic [11:0] WIN_W  = 12'd64,
    parameter logic [11:0] WIN_H  = 12'd64,
    parameter int          ADDR_W = 12
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_de,
    input  logic [23:0]       i_data,
    input  logic              i_capture_req,
    input  logic              i_continuous,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_incomplete,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int TOTAL_I = int'(WIN_W) * int'(WIN_H);
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_I);
    localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(TOTAL_I - 1);

    // Window bounds are widened to 13 bits so WIN_X + WIN_W - 1 cannot overflow.
    localparam logic [12:0] X_LO = {1'b0, WIN_X};
    localparam logic [12:0] X_HI = {1'b0, WIN_X} + {1'b0, WIN_W} - 13'd1;
    localparam logic [12:0] Y_LO = {1'b0, WIN_Y};
    localparam logic [12:0] Y_HI = {1'b0, WIN_Y} + {1'b0, WIN_H} - 13'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              cap_start, end_full, end_short;

    logic              vs_d0_reg, vs_d1_reg, de_d_reg;
    logic              hs_d0_reg, hs_d1_reg;
    logic [11:0]       x_reg, y_reg;
    logic              fs, in_win, hit;

    logic              hit_s1_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;
    logic [CNT_W-1:0]  wr_cnt_reg, iss_cnt_reg;
    logic              busy_reg, done_reg, incomplete_reg;
    logic [17:0]       gray_sum;
    logic              unused_hs;

    assign fs = vs_d1_reg & ~vs_d0_reg;

    // hsync is only carried through the input registers, it never steers anything.
    assign unused_hs = hs_d1_reg;

    // Raster position of the pixel currently on i_data.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0_reg <= 1'b0;
            vs_d1_reg <= 1'b0;
            de_d_reg  <= 1'b0;
            hs_d0_reg <= 1'b0;
            hs_d1_reg <= 1'b0;
            x_reg     <= 12'd0;
            y_reg     <= 12'd0;
        end else begin
            vs_d0_reg <= i_vs;
            vs_d1_reg <= vs_d0_reg;
            de_d_reg  <= i_de;
            hs_d0_reg <= i_hs;
            hs_d1_reg <= hs_d0_reg;
            if (!i_de) begin
                x_reg <= 12'd0;
            end else if (x_reg != 12'hFFF) begin
                x_reg <= x_reg + 12'd1;
            end
            if (fs) begin
                y_reg <= 12'd0;
            end else if (de_d_reg && !i_de && (y_reg != 12'hFFF)) begin
                y_reg <= y_reg + 12'd1;
            end
        end
    end

    assign in_win = ({1'b0, x_reg} >= X_LO) && ({1'b0, x_reg} <= X_HI) &&
                    ({1'b0, y_reg} >= Y_LO) && ({1'b0, y_reg} <= Y_HI);
    assign hit    = (state_reg == ST_CAPTURE) && i_de && in_win && (iss_cnt_reg < TOTAL);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Completion is judged on writes actually issued, so pipelined pixels land first.
    always_comb begin
        state_next = state_reg;
        cap_start  = 1'b0;
        end_full   = 1'b0;
        end_short  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_capture_req) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fs) begin
                    state_next = ST_CAPTURE;
                    cap_start  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (wr_en_reg && (wr_cnt_reg == TOTAL_M1)) begin
                    state_next = ST_DONE;
                    end_full   = 1'b1;
                end else if (fs) begin
                    state_next = ST_DONE;
                    end_short  = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = i_continuous ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage 1: one weighted product per colour channel (B=0, G=1, R=2).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mul
            localparam logic [7:0] COEF = (gi == 2) ? 8'd77 : ((gi == 1) ? 8'd150 : 8'd29);
            logic [15:0] prod_reg;
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_reg <= 16'd0;
                end else begin
                    prod_reg <= {8'd0, i_data[8*gi +: 8]} * {8'd0, COEF};
                end
            end
        end
    endgenerate

    assign gray_sum = {2'b00, g_mul[0].prod_reg} + {2'b00, g_mul[1].prod_reg} +
                      {2'b00, g_mul[2].prod_reg};

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hit_s1_reg     <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_data_reg    <= 8'd0;
            wr_addr_reg    <= '0;
            wr_cnt_reg     <= '0;
            iss_cnt_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            incomplete_reg <= 1'b0;
        end else begin
            hit_s1_reg  <= hit;
            wr_en_reg   <= hit_s1_reg;
            wr_data_reg <= 8'(gray_sum >> 8);
            if (cap_start) begin
                wr_addr_reg <= '0;
                wr_cnt_reg  <= '0;
                iss_cnt_reg <= '0;
            end else begin
                if (wr_en_reg) begin
                    wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                    wr_cnt_reg  <= wr_cnt_reg + CNT_W'(1);
                end
                if (hit) begin
                    iss_cnt_reg <= iss_cnt_reg + CNT_W'(1);
                end
            end
            if (end_full) begin
                incomplete_reg <= 1'b0;
            end else if (end_short) begin
                incomplete_reg <= 1'b1;
            end
            busy_reg <= (state_next != ST_IDLE);
            done_reg <= (state_next == ST_DONE);
        end
    end

    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_incomplete = incomplete_reg;
    assign o_wr_en      = wr_en_reg;
    assign o_wr_addr    = wr_addr_reg;
    assign o_wr_data    = wr_data_reg;

endmodule

// File: tb/tb_region_capture.sv
// Randomized frame-level bench for region_capture: a frame/window model predicts
// every RAM write and every done pulse, a monitor compares them as they appear.
module tb_region_capture;

    localparam int WX = 10;
    localparam int WY = 318;
    localparam int WW = 64;
    localparam int WH = 64;
    localparam int N  = WW * WH;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_hs = 1'b0;
    logic        i_vs = 1'b0;
    logic        i_de = 1'b0;
    logic [23:0] i_data = 24'd0;
    logic        i_capture_req = 1'b0;
    logic        i_continuous = 1'b0;
    logic        o_busy, o_done, o_incomplete, o_wr_en;
    logic [11:0] o_wr_addr;
    logic [7:0]  o_wr_data;

    always #5 pclk = ~pclk;

    region_capture dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .i_hs         (i_hs),
        .i_vs         (i_vs),
        .i_de         (i_de),
        .i_data       (i_data),
        .i_capture_req(i_capture_req),
        .i_continuous (i_continuous),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_incomplete (o_incomplete),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  total = 0;
    int  bad = 0;
    int  m_state = 0;   // 0 idle, 1 armed, 2 capturing
    int  m_cnt = 0;
    int  frame_no = 0;
    int  cyc = 0;
    int  last_wr = -100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int gray(input logic [23:0] d);
        return (77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0])) / 256;
    endfunction

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        logic [11:0] xs, ys;
        xs = 12'(x);
        ys = 12'(y);
        case (mode)
            1:       return 24'hFFFFFF;
            2:       return 24'h000000;
            3:       return {xs[7:0], ys[7:0], 8'h00};
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic step(input logic vs, input logic de, input logic [23:0] d, input logic req);
        @(posedge pclk);
        #1;
        i_vs = vs;
        i_de = de;
        i_hs = ~de;
        i_data = d;
        i_capture_req = req;
        if (req && m_state == 0) m_state = 1;
    endtask

    task automatic frame(input int lines, input int mode, input bit req_vb, input bit req_fs,
                         input bit req_mid, input int abort_at);
        int w;
        int n0;
        logic [23:0] d;
        bit rst_hold;
        rst_hold = 0;
        n0 = exp_q.size();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'd0, req_vb && (i == 0));
        step(1'b0, 1'b0, 24'd0, 1'b0);
        // Frame start: a short capture ends here, an armed capture begins here.
        if (m_state == 2) begin
            done_q.push_back(1);
            m_state = i_continuous ? 1 : 0;
        end else if (m_state == 1) begin
            m_state = 2;
            m_cnt = 0;
        end
        step(1'b0, 1'b0, 24'd0, req_fs);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 24'd0, 1'b0);
        for (int y = 0; y < lines; y++) begin
            w = (y >= WY && y < WY + WH) ? 74 + int'($urandom_range(0, 3)) : int'($urandom_range(1, 2));
            for (int x = 0; x < w; x++) begin
                d = pix(mode, x, y);
                step(1'b0, 1'b1, d, 1'b0);
                if (rst_hold) begin
                    rst_n = 1'b1;
                    rst_hold = 0;
                end
                if (m_state == 2 && x >= WX && x < WX + WW && y >= WY && y < WY + WH) begin
                    exp_q.push_back('{addr: m_cnt, data: gray(d)});
                    m_cnt++;
                    if (m_cnt == N) begin
                        done_q.push_back(0);
                        m_state = i_continuous ? 1 : 0;
                    end
                end
                if (abort_at >= 0 && m_state == 2 && m_cnt == abort_at) begin
                    chk("pre_rst_busy", o_busy, 1);
                    chk("pre_rst_wr_en", o_wr_en, 1);
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_wr_en", o_wr_en, 0);
                    chk("rst_busy", o_busy, 0);
                    chk("rst_done", o_done, 0);
                    chk("rst_addr", o_wr_addr, 0);
                    exp_q.delete();
                    done_q.delete();
                    m_state = 0;
                    rst_hold = 1;
                end
            end
            step(1'b0, 1'b0, 24'd0, req_mid && (y == WY + 2));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'd0, 1'b0);
        frame_no++;
        $display("frame %0d lines=%0d mode=%0d new_writes=%0d model_state=%0d",
                 frame_no, lines, mode, exp_q.size() - n0 + (n0 > 0 ? 0 : 0), m_state);
    endtask

    // Monitor: every write and done pulse must match the model's next prediction.
    always @(negedge pclk) begin
        wr_t e;
        int  inc;
        cyc++;
        if (o_wr_en) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", o_wr_addr, e.addr);
                chk("wr_data", o_wr_data, e.data);
            end
            last_wr = cyc;
        end
        if (o_done) begin
            chk("done_expected", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                inc = done_q.pop_front();
                chk("done_incomplete", o_incomplete, inc);
                if (inc == 0) chk("done_after_last_wr", cyc - last_wr, 1);
            end
        end
    end

    initial begin
        repeat (120000) @(posedge pclk);
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_incomplete", o_incomplete, 0);
        chk("reset_wr_en", o_wr_en, 0);
        chk("reset_wr_addr", o_wr_addr, 0);
        chk("reset_wr_data", o_wr_data, 0);
        rst_n = 1'b1;

        frame(330, 0, 0, 0, 0, -1);
        chk("noreq_busy", o_busy, 0);

        frame(384, 3, 1, 0, 0, -1);
        chk("ramp_busy", o_busy, 0);
        chk("ramp_incomplete", o_incomplete, 0);
        frame(384, 1, 1, 0, 0, -1);
        frame(384, 2, 1, 0, 0, -1);

        frame(320, 0, 1, 0, 0, -1);
        chk("short_busy", o_busy, 1);
        frame(320, 0, 0, 0, 0, -1);
        chk("short_incomplete", o_incomplete, 1);
        chk("short_end_busy", o_busy, 0);

        i_continuous = 1'b1;
        frame(384, 0, 1, 0, 0, -1);
        frame(384, 0, 0, 0, 1, -1);
        frame(384, 0, 0, 0, 1, -1);
        chk("cont_busy", o_busy, 1);
        i_continuous = 1'b0;
        frame(384, 0, 0, 0, 0, -1);
        chk("cont_end_busy", o_busy, 0);
        chk("cont_incomplete", o_incomplete, 0);

        frame(320, 0, 0, 1, 0, -1);
        chk("fsreq_armed_busy", o_busy, 1);
        frame(384, 0, 0, 0, 0, -1);
        chk("fsreq_end_busy", o_busy, 0);

        frame(384, 0, 1, 0, 0, 2000);
        chk("post_rst_busy", o_busy, 0);
        frame(320, 0, 0, 0, 0, -1);
        chk("post_rst_idle_busy", o_busy, 0);
        frame(384, 3, 1, 0, 0, -1);

        for (int k = 0; k < 2; k++) begin
            frame(($urandom_range(0, 1) == 1) ? 384 : 320, 0, 1'($urandom_range(0, 1)), 0, 0, -1);
        end
        frame(320, 0, 0, 0, 0, -1);
        chk("final_busy", o_busy, 32'(m_state != 0));
        repeat (5) @(posedge pclk);
        #1;
        chk("writes_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
